// File: rtl/sr04_meas_sched.sv
// Measurement scheduler for the sr04_ctrl ranging engine: issues start pulses
// (manual single-shot or periodic auto), guards each measurement with a
// timeout and, in auto mode, smooths the result with a 2^AVG_LOG2 moving
// average before it is shown on fnd_ctrl.
module sr04_meas_sched #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned PERIOD_MS  = 100,
  parameter int unsigned TIMEOUT_MS = 30,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DIST_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_single,
  input  logic              btn_mode,
  input  logic              dist_done,
  input  logic [DIST_W-1:0] distance,
  output logic              start,
  output logic [DIST_W-1:0] dist_out,
  output logic              dist_valid,
  output logic              auto_mode,
  output logic              timeout_err,
  output logic              busy
);

  localparam int unsigned PERIOD_CYC  = CLK_HZ / 1000 * PERIOD_MS;
  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int unsigned PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned N     = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = DIST_W + AVG_LOG2;

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, ACCUM} state_t;

  state_t              state_q, state_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic                pending_q, pending_d;
  logic                auto_q, auto_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                terr_q, terr_d;
  logic [DIST_W-1:0]   sample_q, sample_d;
  logic [DIST_W-1:0]   avg_buf_q [N];
  logic [DIST_W-1:0]   avg_buf_d [N];
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                primed_q, primed_d;
  logic [DIST_W-1:0]   dout_q, dout_d;
  logic                dvalid_q, dvalid_d;

  logic go_trig;
  logic to_expire;
  logic per_wrap;

  assign to_expire = (to_q == TO_W'(TIMEOUT_CYC - 1));
  assign per_wrap  = auto_q && (per_q == PER_W'(PERIOD_CYC - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; dist_done takes priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    go_trig = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_single || (auto_q && pending_q)) begin
          go_trig = 1'b1;
          state_d = TRIG;
        end
      end
      TRIG:  state_d = WAIT;
      WAIT: begin
        if (dist_done)      state_d = ACCUM;
        else if (to_expire) state_d = IDLE;
      end
      ACCUM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: period timer, pending request, timeout, averaging.
  always_comb begin
    auto_d    = auto_q ^ btn_mode;
    per_d     = per_q;
    pending_d = pending_q;
    to_d      = to_q;
    terr_d    = terr_q;
    sample_d  = sample_q;
    avg_buf_d = avg_buf_q;
    ptr_d     = ptr_q;
    sum_d     = sum_q;
    primed_d  = primed_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;

    if (btn_mode)    per_d = '0;
    else if (auto_q) per_d = per_wrap ? '0 : per_q + PER_W'(1);

    // Mode toggle is applied before a same-cycle trigger consumes the request.
    if (per_wrap) pending_d = 1'b1;
    if (btn_mode) pending_d = auto_d;
    if (go_trig)  pending_d = 1'b0;

    if (state_q == TRIG) to_d = '0;
    else if (state_q == WAIT) to_d = to_q + TO_W'(1);

    if (state_q == WAIT) begin
      if (dist_done) begin
        sample_d = distance;
        terr_d   = 1'b0;
      end else if (to_expire) begin
        terr_d = 1'b1;
      end
    end

    if (state_q == ACCUM) begin
      dvalid_d = 1'b1;
      if (auto_q) begin
        if (!primed_q) begin
          for (int unsigned i = 0; i < N; i++) avg_buf_d[i] = sample_q;
          sum_d    = {sample_q, {AVG_LOG2{1'b0}}};
          ptr_d    = '0;
          primed_d = 1'b1;
        end else begin
          sum_d            = sum_q - SUM_W'(avg_buf_q[ptr_q]) + SUM_W'(sample_q);
          avg_buf_d[ptr_q] = sample_q;
          ptr_d            = ptr_q + AVG_LOG2'(1);
        end
        dout_d = sum_d[SUM_W-1:AVG_LOG2];
      end else begin
        dout_d   = sample_q;
        primed_d = 1'b0;
      end
    end

    if (btn_mode) primed_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q     <= '0;
      pending_q <= 1'b0;
      auto_q    <= 1'b0;
      to_q      <= '0;
      terr_q    <= 1'b0;
      sample_q  <= '0;
      for (int unsigned i = 0; i < N; i++) avg_buf_q[i] <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      primed_q  <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
    end else begin
      per_q     <= per_d;
      pending_q <= pending_d;
      auto_q    <= auto_d;
      to_q      <= to_d;
      terr_q    <= terr_d;
      sample_q  <= sample_d;
      avg_buf_q <= avg_buf_d;
      ptr_q     <= ptr_d;
      sum_q     <= sum_d;
      primed_q  <= primed_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
    end
  end

  assign start       = (state_q == TRIG);
  assign busy        = (state_q != IDLE);
  assign dist_out    = dout_q;
  assign dist_valid  = dvalid_q;
  assign auto_mode   = auto_q;
  assign timeout_err = terr_q;

endmodule
